mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 48, memory word width (one scalar or one 6x8 vector).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 48, memory address width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive denied host cycles before forced host grant; legal range 1..15.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 cpuReq  in  1  memory-stage access request, level, sampled each cycle.
REQ-008 cpuWrite  in  1  1=store, 0=load.
REQ-009 cpuAddress  in  ADDRESS_WIDTH  memory-stage address.
REQ-010 cpuWriteData  in  DATA_WIDTH  store data.
REQ-011 cpuStall  out  1  pipeline must hold memory stage and upstream this cycle.
REQ-012 cpuReadData  out  DATA_WIDTH  load result.
REQ-013 cpuReadValid  out  1  cpuReadData valid, one-cycle pulse.
REQ-014 hostValid  in  1  host loader request valid.
REQ-015 hostReady  out  1  host request accepted this cycle.
REQ-016 hostWrite, hostAddress, hostWriteData  in  1/ADDRESS_WIDTH/DATA_WIDTH  host command fields.
REQ-017 hostReadData  out  DATA_WIDTH; hostReadValid  out  1  host read response.
REQ-018 memWriteEnable  out  1; memAddress  out  ADDRESS_WIDTH; memWriteData  out  DATA_WIDTH  single memory port.
REQ-019 memReadData  in  DATA_WIDTH  memory read data, valid one cycle after address presented.

Function
REQ-020 SHALL grant at most one requester per cycle; grant is combinational from inputs and registered state.
REQ-021 Grant rule: host if hostValid and (not cpuReq or starveCount == STARVE_LIMIT); else CPU if cpuReq; else none.
REQ-022 On CPU grant: memAddress=cpuAddress, memWriteData=cpuWriteData, memWriteEnable=cpuWrite; same-cycle for host grant with host fields.
REQ-023 No grant: memWriteEnable=0, memAddress/memWriteData=0.
REQ-024 cpuStall = cpuReq and not CPU grant; hostReady = host grant.
REQ-025 Host handshake: transfer when hostValid and hostReady; host SHALL hold fields stable while hostValid and not hostReady; hostValid deassertion before acceptance is legal (request withdrawn).
REQ-026 starveCount: increments (saturating at STARVE_LIMIT) each cycle hostValid=1 and host not granted; clears to 0 on host grant or hostValid=0.
REQ-027 Owner register states NONE, CPU_RD, HOST_RD: next state CPU_RD on granted CPU load, HOST_RD on granted host read, else NONE (writes -> NONE).
REQ-028 Read latency exactly 1 cycle: state CPU_RD -> cpuReadValid=1, cpuReadData=memReadData; HOST_RD -> hostReadValid=1, hostReadData=memReadData; otherwise valid=0, data=0.
REQ-029 Back-to-back grants every cycle SHALL be supported; response of cycle N coexists with grant of cycle N+1.
REQ-030 Forced host grant SHALL last exactly one cycle; CPU regains priority next cycle.

Reset
REQ-031 While reset=1: no grant, memWriteEnable=0, hostReady=0, cpuStall=cpuReq.
REQ-032 After reset edge: starveCount=0, owner=NONE, cpuReadValid=0, hostReadValid=0, read data outputs 0.
REQ-033 Reset mid-read SHALL drop the pending response; no readValid in the cycle after reset deasserts.

Structure
REQ-034 Shared package cpu_pkg SHALL hold enum mem_owner_t {NONE, CPU_RD, HOST_RD} and constant DEFAULT_STARVE_LIMIT=4.
REQ-035 Starvation counter SHALL be a sub-module starve_counter (inc, clear, saturate, atLimit output).

Verification
REQ-036 cpuReq=1 load addr 0x10, hostValid=0 -> memAddress=0x10, cpuStall=0; next cycle cpuReadValid=1 with memReadData.
REQ-037 cpuReq=0, hostValid=1 write addr 0x20 data 0xABCD -> hostReady=1, memWriteEnable=1 same cycle; no readValid next cycle.
REQ-038 cpuReq=1 continuously, hostValid=1 from cycle 0 -> host denied cycles 0-3, granted cycle 4 with cpuStall=1, CPU granted cycle 5, starveCount=0.
REQ-039 Alternating CPU load / host read every cycle -> each response routed to correct port exactly 1 cycle after its grant, none lost.
REQ-040 Host read granted, reset asserted next cycle -> hostReadValid=0 throughout and after reset; all outputs at REQ-032 values.
REQ-041 hostValid=1 for 2 denied cycles then 0 -> starveCount returns to 0; later request needs full 4 denials before forced grant.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-port arbiter.
//   mem_owner_t          : which requester owns the read response due next cycle
//   DEFAULT_STARVE_LIMIT : default number of host denials before a forced host grant
//   STARVE_COUNT_WIDTH   : counter width, wide enough for the largest legal limit (15)
package cpu_pkg;

    localparam int unsigned DEFAULT_STARVE_LIMIT = 4;
    localparam int unsigned STARVE_COUNT_WIDTH   = 4;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        CPU_RD  = 2'd1,
        HOST_RD = 2'd2
    } mem_owner_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating starvation counter for the host requester.
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset, clears the count
//   inc     : host was denied this cycle
//   clear   : host was granted or is not requesting; has priority over inc
//   atLimit : count has reached LIMIT, the next host request must be granted
module starve_counter
    import cpu_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    output logic atLimit
);

    localparam logic [STARVE_COUNT_WIDTH-1:0] LimitValue = STARVE_COUNT_WIDTH'(LIMIT);

    logic [STARVE_COUNT_WIDTH-1:0] countQ;
    logic [STARVE_COUNT_WIDTH-1:0] countD;

    always_comb begin
        countD = countQ;
        if (clear) begin
            countD = '0;
        end else if (inc && (countQ != LimitValue)) begin
            countD = countQ + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            countQ <= '0;
        end else begin
            countQ <= countD;
        end
    end

    assign atLimit = (countQ == LimitValue);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the CPU memory stage and a host loader.
// CPU has priority unless the host has been denied STARVE_LIMIT cycles in a row, in
// which case the host wins for exactly one cycle. Reads return one cycle after grant.
//   clock, reset                          : clock and synchronous active-high reset
//   cpuReq/cpuWrite/cpuAddress/cpuWriteData: CPU request (level, sampled each cycle)
//   cpuStall                              : CPU request not granted this cycle
//   cpuReadData/cpuReadValid              : CPU load response (one-cycle pulse)
//   hostValid/hostWrite/hostAddress/hostWriteData : host request, valid/ready handshake
//   hostReady                             : host request accepted this cycle
//   hostReadData/hostReadValid            : host read response (one-cycle pulse)
//   memWriteEnable/memAddress/memWriteData: memory port command
//   memReadData                           : memory read data, one cycle after address
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 48,
    parameter int unsigned ADDRESS_WIDTH = 48,
    parameter int unsigned STARVE_LIMIT  = DEFAULT_STARVE_LIMIT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpuReq,
    input  logic                     cpuWrite,
    input  logic [ADDRESS_WIDTH-1:0] cpuAddress,
    input  logic [DATA_WIDTH-1:0]    cpuWriteData,
    output logic                     cpuStall,
    output logic [DATA_WIDTH-1:0]    cpuReadData,
    output logic                     cpuReadValid,
    input  logic                     hostValid,
    output logic                     hostReady,
    input  logic                     hostWrite,
    input  logic [ADDRESS_WIDTH-1:0] hostAddress,
    input  logic [DATA_WIDTH-1:0]    hostWriteData,
    output logic [DATA_WIDTH-1:0]    hostReadData,
    output logic                     hostReadValid,
    output logic                     memWriteEnable,
    output logic [ADDRESS_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0]    memWriteData,
    input  logic [DATA_WIDTH-1:0]    memReadData
);

    logic       hostGrant;
    logic       cpuGrant;
    logic       starveAtLimit;
    mem_owner_t ownerQ;
    mem_owner_t ownerD;

    starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_counter (
        .clock  (clock),
        .reset  (reset),
        .inc    (hostValid && !hostGrant),
        .clear  (hostGrant || !hostValid),
        .atLimit(starveAtLimit)
    );

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        hostGrant = 1'b0;
        cpuGrant  = 1'b0;
        if (!reset) begin
            if (hostValid && (!cpuReq || starveAtLimit)) begin
                hostGrant = 1'b1;
            end else if (cpuReq) begin
                cpuGrant = 1'b1;
            end
        end
    end

    // Owner register: records whose read is in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            ownerQ <= NONE;
        end else begin
            ownerQ <= ownerD;
        end
    end

    always_comb begin
        ownerD = NONE;
        if (cpuGrant && !cpuWrite) begin
            ownerD = CPU_RD;
        end else if (hostGrant && !hostWrite) begin
            ownerD = HOST_RD;
        end
    end

    // Outputs: memory command, handshakes and response routing.
    always_comb begin
        memWriteEnable = 1'b0;
        memAddress     = '0;
        memWriteData   = '0;
        if (cpuGrant) begin
            memWriteEnable = cpuWrite;
            memAddress     = cpuAddress;
            memWriteData   = cpuWriteData;
        end else if (hostGrant) begin
            memWriteEnable = hostWrite;
            memAddress     = hostAddress;
            memWriteData   = hostWriteData;
        end

        cpuStall  = cpuReq && !cpuGrant;
        hostReady = hostGrant;

        // Gating with reset drops a response whose slot coincides with a reset cycle.
        cpuReadValid  = 1'b0;
        cpuReadData   = '0;
        hostReadValid = 1'b0;
        hostReadData  = '0;
        if (!reset) begin
            unique case (ownerQ)
                CPU_RD: begin
                    cpuReadValid = 1'b1;
                    cpuReadData  = memReadData;
                end
                HOST_RD: begin
                    hostReadValid = 1'b1;
                    hostReadData  = memReadData;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned DW    = 48;
    localparam int unsigned AW    = 48;
    localparam int unsigned LIMIT = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpuReq, cpuWrite;
    logic [AW-1:0] cpuAddress;
    logic [DW-1:0] cpuWriteData;
    logic          cpuStall;
    logic [DW-1:0] cpuReadData;
    logic          cpuReadValid;
    logic          hostValid, hostReady, hostWrite;
    logic [AW-1:0] hostAddress;
    logic [DW-1:0] hostWriteData;
    logic [DW-1:0] hostReadData;
    logic          hostReadValid;
    logic          memWriteEnable;
    logic [AW-1:0] memAddress;
    logic [DW-1:0] memWriteData;
    logic [DW-1:0] memReadData = '0;

    int assertCount = 0;
    int failCount   = 0;
    bit checkOn     = 1'b0;

    mem_port_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cpuReq        (cpuReq),
        .cpuWrite      (cpuWrite),
        .cpuAddress    (cpuAddress),
        .cpuWriteData  (cpuWriteData),
        .cpuStall      (cpuStall),
        .cpuReadData   (cpuReadData),
        .cpuReadValid  (cpuReadValid),
        .hostValid     (hostValid),
        .hostReady     (hostReady),
        .hostWrite     (hostWrite),
        .hostAddress   (hostAddress),
        .hostWriteData (hostWriteData),
        .hostReadData  (hostReadData),
        .hostReadValid (hostReadValid),
        .memWriteEnable(memWriteEnable),
        .memAddress    (memAddress),
        .memWriteData  (memWriteData),
        .memReadData   (memReadData)
    );

    always #5 clock = ~clock;

    // Memory stand-in: read data is a fixed function of the address presented last cycle.
    function automatic logic [DW-1:0] memFn(input logic [AW-1:0] a);
        return (a * 48'd3) ^ 48'h0000_5A5A_1111;
    endfunction

    always @(posedge clock) memReadData <= memFn(memAddress);

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: starvation count, pending response owner (0 none, 1 cpu, 2 host)
    // and the address that response was read from.
    int            mStarve = 0, nStarve = 0;
    int            mPend = 0, nPend = 0;
    logic [AW-1:0] mPendAddr = '0, nPendAddr = '0;

    always @(negedge clock) begin
        if (checkOn) begin
            bit            eHost, eCpu;
            logic          eWe;
            logic [AW-1:0] eAddr;
            logic [DW-1:0] eWd;
            eHost = 1'b0;
            eCpu  = 1'b0;
            if (!reset) begin
                if (hostValid && (!cpuReq || mStarve == LIMIT)) eHost = 1'b1;
                else if (cpuReq) eCpu = 1'b1;
            end
            eWe   = eCpu ? cpuWrite : (eHost ? hostWrite : 1'b0);
            eAddr = eCpu ? cpuAddress : (eHost ? hostAddress : '0);
            eWd   = eCpu ? cpuWriteData : (eHost ? hostWriteData : '0);
            check("m.memWriteEnable", 48'(memWriteEnable), 48'(eWe));
            check("m.memAddress", memAddress, eAddr);
            check("m.memWriteData", memWriteData, eWd);
            check("m.cpuStall", 48'(cpuStall), 48'(cpuReq && !eCpu));
            check("m.hostReady", 48'(hostReady), 48'(eHost));
            check("m.cpuReadValid", 48'(cpuReadValid), 48'(!reset && mPend == 1));
            check("m.cpuReadData", cpuReadData,
                  (!reset && mPend == 1) ? memFn(mPendAddr) : '0);
            check("m.hostReadValid", 48'(hostReadValid), 48'(!reset && mPend == 2));
            check("m.hostReadData", hostReadData,
                  (!reset && mPend == 2) ? memFn(mPendAddr) : '0);
            if (reset) begin
                nStarve = 0;
                nPend   = 0;
            end else begin
                nStarve = (hostValid && !eHost) ? ((mStarve < LIMIT) ? mStarve + 1 : LIMIT) : 0;
                nPend   = (eCpu && !cpuWrite) ? 1 : ((eHost && !hostWrite) ? 2 : 0);
                nPendAddr = eAddr;
            end
        end
    end

    always @(posedge clock) begin
        if (checkOn) begin
            mStarve   <= nStarve;
            mPend     <= nPend;
            mPendAddr <= nPendAddr;
        end
    end

    // Applies one cycle of inputs just after the edge and returns at the following negedge.
    task automatic step(input logic r, input logic cReq, input logic cWr,
                        input logic [AW-1:0] cA, input logic [DW-1:0] cD,
                        input logic hV, input logic hWr,
                        input logic [AW-1:0] hA, input logic [DW-1:0] hD);
        @(posedge clock);
        #1;
        reset = r; cpuReq = cReq; cpuWrite = cWr; cpuAddress = cA; cpuWriteData = cD;
        hostValid = hV; hostWrite = hWr; hostAddress = hA; hostWriteData = hD;
        @(negedge clock);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [AW-1:0] prevAddr;
        reset = 1'b1; cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddress = '0; cpuWriteData = '0;
        hostValid = 1'b0; hostWrite = 1'b0; hostAddress = '0; hostWriteData = '0;
        @(posedge clock);
        #1;
        checkOn = 1'b1;

        // Reset held: no grants, CPU sees a stall, reset state on the response side.
        step(1'b1, 1'b1, 1'b0, 48'h10, '0, 1'b0, 1'b0, '0, '0);
        check("rst.cpuStall", 48'(cpuStall), 48'd1);
        check("rst.memWriteEnable", 48'(memWriteEnable), 48'd0);
        check("rst.cpuReadValid", 48'(cpuReadValid), 48'd0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 48'h20, 48'h1);
        check("rst.hostReady", 48'(hostReady), 48'd0);
        check("rst.memWriteEnable2", 48'(memWriteEnable), 48'd0);

        // CPU load with no host traffic.
        step(1'b0, 1'b1, 1'b0, 48'h10, '0, 1'b0, 1'b0, '0, '0);
        check("load.memAddress", memAddress, 48'h10);
        check("load.cpuStall", 48'(cpuStall), 48'd0);
        idle();
        check("load.cpuReadValid", 48'(cpuReadValid), 48'd1);
        check("load.cpuReadData", cpuReadData, 48'h5A5A_1121);

        // Host write with CPU idle.
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 48'h20, 48'hABCD);
        check("hwr.hostReady", 48'(hostReady), 48'd1);
        check("hwr.memWriteEnable", 48'(memWriteEnable), 48'd1);
        check("hwr.memAddress", memAddress, 48'h20);
        check("hwr.memWriteData", memWriteData, 48'hABCD);
        idle();
        check("hwr.hostReadValid", 48'(hostReadValid), 48'd0);
        check("hwr.cpuReadValid", 48'(cpuReadValid), 48'd0);

        // Continuous CPU loads against a host read: forced grants at cycles 4 and 9.
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b1, 1'b0, 48'h100 + 48'(c), '0, 1'b1, 1'b0, 48'h30, '0);
            check($sformatf("starve.hostReady[%0d]", c), 48'(hostReady),
                  48'((c == 4) || (c == 9)));
            check($sformatf("starve.cpuStall[%0d]", c), 48'(cpuStall),
                  48'((c == 4) || (c == 9)));
            if (c == 4) check("starve.memAddress", memAddress, 48'h30);
            if (c == 5) begin
                check("starve.hostReadValid", 48'(hostReadValid), 48'd1);
                check("starve.hostReadData", hostReadData, 48'h5A5A_1181);
            end
        end
        idle();
        check("starve.lastHostReadValid", 48'(hostReadValid), 48'd1);

        // Withdrawn host request resets the starvation count.
        step(1'b0, 1'b1, 1'b0, 48'h200, '0, 1'b1, 1'b0, 48'h50, '0);
        step(1'b0, 1'b1, 1'b0, 48'h200, '0, 1'b1, 1'b0, 48'h50, '0);
        check("withdraw.hostReady", 48'(hostReady), 48'd0);
        step(1'b0, 1'b1, 1'b0, 48'h200, '0, 1'b0, 1'b0, 48'h50, '0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, 48'h200, '0, 1'b1, 1'b0, 48'h50, '0);
            check($sformatf("withdraw.retry[%0d]", k), 48'(hostReady), 48'(k == 4));
        end

        // Alternating CPU load / host read every cycle.
        idle();
        prevAddr = '0;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) idle();
            else if (i % 2 == 0) step(1'b0, 1'b1, 1'b0, 48'h300 + 48'(i), '0, 1'b0, 1'b0, '0, '0);
            else step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 48'h400 + 48'(i), '0);
            if (i > 0) begin
                check($sformatf("alt.cpuReadValid[%0d]", i), 48'(cpuReadValid),
                      48'((i - 1) % 2 == 0));
                check($sformatf("alt.hostReadValid[%0d]", i), 48'(hostReadValid),
                      48'((i - 1) % 2 == 1));
                check($sformatf("alt.data[%0d]", i),
                      ((i - 1) % 2 == 0) ? cpuReadData : hostReadData, memFn(prevAddr));
            end
            prevAddr = (i % 2 == 0) ? 48'h300 + 48'(i) : 48'h400 + 48'(i);
        end

        // Reset right after a host read grant drops the response.
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 48'h40, '0);
        check("rstrd.hostReady", 48'(hostReady), 48'd1);
        step(1'b1, 1'b1, 1'b0, 48'h44, '0, 1'b0, 1'b0, '0, '0);
        check("rstrd.hostReadValid", 48'(hostReadValid), 48'd0);
        check("rstrd.hostReadData", hostReadData, 48'd0);
        check("rstrd.cpuStall", 48'(cpuStall), 48'd1);
        idle();
        check("rstrd.hostReadValidAfter", 48'(hostReadValid), 48'd0);
        check("rstrd.cpuReadValidAfter", 48'(cpuReadValid), 48'd0);
        check("rstrd.cpuReadData", cpuReadData, 48'd0);

        // Same for a CPU load.
        step(1'b0, 1'b1, 1'b0, 48'h60, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        check("rstcpu.cpuReadValid", 48'(cpuReadValid), 48'd0);
        idle();
        check("rstcpu.cpuReadValidAfter", 48'(cpuReadValid), 48'd0);

        idle();
        checkOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
